// File: rtl/signed_diff_accum_pkg.sv
// rtl/signed_diff_accum_pkg.sv - shared types and helpers for the signed window accumulator
package signed_diff_accum_pkg;

    localparam int DEF_IN_W    = 5;
    localparam int DEF_ACC_W   = 8;
    localparam int DEF_WIN_LEN = 4;

    // The block has no FSM of its own; this names the three observable
    // conditions formed by the sample counter and the pending output flag.
    typedef enum logic [1:0] {
        ST_ACCUM         = 2'd0,
        ST_ACCUM_PENDING = 2'd1,
        ST_STALLED       = 2'd2
    } acc_status_e;

    function automatic acc_status_e acc_status(
        input logic last_sample,
        input logic pending,
        input logic out_ready
    );
        if (last_sample && pending && !out_ready) begin
            return ST_STALLED;
        end else if (pending) begin
            return ST_ACCUM_PENDING;
        end
        return ST_ACCUM;
    endfunction

endpackage

// File: rtl/signed_diff_accum_if.sv
// rtl/signed_diff_accum_if.sv - difference input stream and window result stream
interface signed_diff_accum_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8
);
    logic             inValid;
    logic [IN_W-1:0]  inData;
    logic             inReady;
    logic             outValid;
    logic             outReady;
    logic [ACC_W-1:0] outSum;
    logic             outSat;

    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, outSum, outSat
    );

    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, outSum, outSat
    );
endinterface

// File: rtl/signed_diff_accum_sat_add.sv
// rtl/signed_diff_accum_sat_add.sv - combinational saturating signed add of a narrow sample onto a wide base
module sat_add_signed #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] base,
    input  logic [IN_W-1:0]  in_data,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] base_x;
    logic [ACC_W:0] in_x;
    logic [ACC_W:0] wide;

    // One guard bit is enough: the ACC_W+1 sum cannot wrap, so disagreement
    // of the top two bits means the result left the ACC_W range.
    always_comb begin
        base_x = {base[ACC_W-1], base};
        in_x   = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
        wide   = base_x + in_x;
        sat    = 1'b0;
        sum    = wide[ACC_W-1:0];
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sat = 1'b1;
            sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/signed_diff_accum.sv
// rtl/signed_diff_accum.sv - saturating per-window sum of signed differences with a registered result
import signed_diff_accum_pkg::*;

module signed_diff_accum #(
    parameter int IN_W    = DEF_IN_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic               clk,
    input  logic               rst,
    signed_diff_accum_if.slave bus
);
    localparam int              CNT_W    = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

    logic [ACC_W-1:0] acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             win_sat_q, win_sat_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_sat_q, out_sat_d;

    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic             sat;
    logic             last_sample;
    logic             in_ready;
    logic             accept;
    acc_status_e      status;

    sat_add_signed #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .base    (base),
        .in_data (bus.inData),
        .sum     (sum),
        .sat     (sat)
    );

    // Stall only when the closing sample would overwrite an unconsumed result.
    always_comb begin
        last_sample = (cnt_q == CNT_LAST);
        status      = acc_status(last_sample, out_valid_q, bus.outReady);
        in_ready    = (status != ST_STALLED);
        accept      = bus.inValid && in_ready;
        base        = (cnt_q == '0) ? '0 : acc_q;
    end

    // Next-state: accumulate, close the window into the output register, retire results.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        win_sat_d   = win_sat_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;

        if (out_valid_q && bus.outReady) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (last_sample) begin
                out_valid_d = 1'b1;
                out_sum_d   = sum;
                out_sat_d   = win_sat_q | sat;
                acc_d       = '0;
                cnt_d       = '0;
                win_sat_d   = 1'b0;
            end else begin
                acc_d       = sum;
                cnt_d       = cnt_q + 1'b1;
                win_sat_d   = win_sat_q | sat;
            end
        end
    end

    // State registers; reset discards any partial window and pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            win_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            win_sat_q   <= win_sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = out_valid_q;
    assign bus.outSum   = out_sum_q;
    assign bus.outSat   = out_sat_q;

endmodule

// File: tb/tb_signed_diff_accum.sv
// tb/tb_signed_diff_accum.sv - scoreboard bench for signed_diff_accum at WIN_LEN 4 and 16
module tb_signed_diff_accum;

    typedef struct {
        logic [7:0] sum;
        logic       sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signed_diff_accum_if #(.IN_W(5), .ACC_W(8)) if4 ();
    signed_diff_accum_if #(.IN_W(5), .ACC_W(8)) if16 ();

    signed_diff_accum #(.IN_W(5), .ACC_W(8), .WIN_LEN(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    signed_diff_accum #(.IN_W(5), .ACC_W(8), .WIN_LEN(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    exp_t q4[$];
    exp_t q16[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int which, input int s, input logic sat);
        exp_t e;
        logic [31:0] sv;
        sv    = s;
        e.sum = sv[7:0];
        e.sat = sat;
        if (which == 0) q4.push_back(e);
        else            q16.push_back(e);
    endtask

    // Present one sample and hold it until accepted; caller is just after a rising edge.
    task automatic send(input int which, input int d);
        logic [31:0] dv;
        bit          done;
        int          n;
        dv   = d;
        done = 1'b0;
        n    = 0;
        if (which == 0) begin if4.inValid = 1'b1;  if4.inData = dv[4:0];  end
        else            begin if16.inValid = 1'b1; if16.inData = dv[4:0]; end
        while (!done && n < 50) begin
            @(negedge clk);
            if ((which == 0) ? if4.inReady : if16.inReady) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n++;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
            @(posedge clk);
            #1;
        end
        if (which == 0) if4.inValid = 1'b0;
        else            if16.inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 4-sample instance: every handshake must match the next expected window.
    always @(negedge clk) begin
        if (mon_en && if4.outValid && if4.outReady) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out4 actual=%0h required=none", if4.outSum);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("sum4", 32'(if4.outSum), 32'(e.sum));
                check("sat4", 32'(if4.outSat), 32'(e.sat));
            end
        end
    end

    // Scoreboard for the 16-sample instance.
    always @(negedge clk) begin
        if (mon_en && if16.outValid && if16.outReady) begin
            if (q16.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out16 actual=%0h required=none", if16.outSum);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check("sum16", 32'(if16.outSum), 32'(e.sum));
                check("sat16", 32'(if16.outSat), 32'(e.sat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        if4.inValid   = 1'b1;
        if4.inData    = 5'd7;
        if4.outReady  = 1'b1;
        if16.inValid  = 1'b1;
        if16.inData   = 5'd7;
        if16.outReady = 1'b1;

        // Reset held with inValid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(if4.outValid), 32'd0);
        check("rst_out_sum",   32'(if4.outSum),   32'd0);
        check("rst_out_sat",   32'(if4.outSat),   32'd0);
        check("rst_out_valid16", 32'(if16.outValid), 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        if4.inValid  = 1'b0;
        if16.inValid = 1'b0;
        @(negedge clk);
        check("rst_in_ready",   32'(if4.inReady),  32'd1);
        check("rst_in_ready16", 32'(if16.inReady), 32'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic back-to-back window: 3-5+7-1 = 4, with latency and drop checks
        push(0, 4, 1'b0);
        send(0, 3);
        send(0, -5);
        send(0, 7);
        send(0, -1);
        @(negedge clk);
        check("lat_out_valid", 32'(if4.outValid), 32'd1);
        @(negedge clk);
        check("drop_out_valid", 32'(if4.outValid), 32'd0);
        idle(1);

        // Same samples with two idle cycles between each
        push(0, 4, 1'b0);
        send(0, 3);  idle(2);
        send(0, -5); idle(2);
        send(0, 7);  idle(2);
        send(0, -1); idle(3);

        // Extreme inputs that stay in range: -64 and +60
        push(0, -64, 1'b0);
        repeat (4) send(0, -16);
        push(0, 60, 1'b0);
        repeat (4) send(0, 15);
        idle(3);

        // Saturation at WIN_LEN=16, then sticky flag cleared in the next window
        push(1, -128, 1'b1);
        repeat (16) send(1, -16);
        push(1, 16, 1'b0);
        repeat (16) send(1, 1);
        idle(3);

        // Backpressure: window A held, B's closing sample stalls until A is taken
        if4.outReady = 1'b0;
        push(0, 4, 1'b0);
        repeat (4) send(0, 1);
        push(0, 8, 1'b0);
        repeat (3) send(0, 2);
        if4.inValid = 1'b1;
        if4.inData  = 5'd2;
        repeat (3) @(negedge clk);
        check("bp_in_ready",  32'(if4.inReady),  32'd0);
        check("bp_out_valid", 32'(if4.outValid), 32'd1);
        check("bp_out_sum",   32'(if4.outSum),   32'd4);
        @(posedge clk);
        #1;
        if4.outReady = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(if4.inReady), 32'd1);
        @(posedge clk);
        #1;
        if4.inValid = 1'b0;
        @(negedge clk);
        check("bp_b_out_valid", 32'(if4.outValid), 32'd1);
        check("bp_b_out_sum",   32'(if4.outSum),   32'd8);
        idle(3);

        // Mid-window reset discards 5+5; the next full window gives 10
        send(0, 5);
        send(0, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(0, 10, 1'b0);
        send(0, 1);
        send(0, 2);
        send(0, 3);
        send(0, 4);
        idle(5);

        check("q4_drained",  32'(q4.size()),  32'd0);
        check("q16_drained", 32'(q16.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_diff_accum.md
Name: signed_diff_accum

Overview:
Downstream consumer of the signed subtractor pipeline's difference stream. It sums every WIN_LEN accepted signed differences into a saturating window total and presents each total on a registered valid/ready output. A separate output register lets accumulation of the next window continue while the previous total waits for the consumer.

Parameters:
IN_W, 5, width of signed input difference (two's complement)
ACC_W, 8, width of signed window sum; must satisfy ACC_W >= IN_W
WIN_LEN, 4, samples per window; must be >= 2

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
inValid  input  1  inData is valid this cycle
inData  input  IN_W  signed difference sample
inReady  output  1  block accepts inData this cycle
outValid  output  1  outSum/outSat hold a completed window
outReady  input  1  consumer takes the window result
outSum  output  ACC_W  signed window sum, saturated
outSat  output  1  saturation occurred at least once in this window

Behaviour:
- Reset (rst=1 at a clock edge) clears everything. acc=0, cnt=0, winSat=0, outValid=0, outSum=0, outSat=0. inReady is 1 one cycle after reset.
- Reset has priority over all other events. A reset mid-window discards the partial sum and any pending output.
- Accept: a sample is accepted when inValid && inReady at a rising edge. If inValid=0, nothing changes.
- Arithmetic:
  - inData is sign-extended to ACC_W+1 bits.
  - base = 0 if cnt==0, else acc.
  - sum = base + sext(inData), computed in ACC_W+1 bits.
  - Clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets winSat.
  - winSat is sticky within the window.
- Counter: cnt counts 0..WIN_LEN-1. It increments on each accept and wraps to 0 on the WIN_LEN-th accept.
- Window completion (accept while cnt==WIN_LEN-1):
  - At the same edge, outSum <= clamped sum and outSat <= winSat OR (this sample clamped).
  - Also at that edge: outValid <= 1, acc <= 0, winSat <= 0.
  - Latency: outValid is high in the cycle after the edge that accepts the last sample.
- Output handshake: outValid && outReady at an edge clears outValid, unless a new window completes at the same edge, in which case outValid stays 1 with new data.
- outSum/outSat are stable while outValid && !outReady.
- inReady = !(cnt==WIN_LEN-1 && outValid && !outReady).
  - This is a combinational path from outReady. It is the only stall case: completing a window while the previous result is unconsumed.
  - Samples 0..WIN_LEN-2 of the next window are always accepted.
- inReady never depends on inValid. outValid never depends combinationally on any input.
- No state machine beyond cnt and outValid. States are: ACCUM, ACCUM+PENDING, STALLED (cnt==WIN_LEN-1 && outValid && !outReady).

Decomposition:
- No shared package is needed. The saturation min/max are localparams derived from ACC_W.
- One natural sub-module: sat_add_signed (parameters IN_W, ACC_W). It is combinational: base + sext(inData), clamp, and sat flag. Reuse it for later saturating stages.

Test Plan:
- Reset: hold rst=1 for 2 cycles with inValid=1 -> outValid=0, outSum=0, outSat=0. inReady=1 after release, and no sample is counted during reset.
- Basic window, defaults, outReady=1: accept 3, -5, 7, -1 back-to-back -> outValid=1 one cycle after the 4th accept, outSum=4, outSat=0. outValid drops the next cycle.
- Gaps: the same four samples with inValid=0 for 2 cycles between each -> identical result 4. Idle cycles are not counted.
- Saturation, WIN_LEN=16: 16 samples of -16 -> outSum=-128, outSat=1. The following window of 16 samples of +1 -> outSum=16, outSat=0 (sticky flag cleared).
- Backpressure, outReady=0: window A = 1,1,1,1 gives outSum=4 held. Window B = 2,2,2 is accepted, then inReady=0 while the 4th sample (2) is presented. Raise outReady -> A is handshaken and B's 4th sample is accepted at the same edge; next cycle outValid=1, outSum=8.
- Mid-window reset: accept 5, 5, then rst for 1 cycle, then accept 1, 2, 3, 4 -> outSum=10. No output from the aborted window.
